// File: rtl/divider_datapath.sv
// divider_datapath
//   Restoring shift/subtract division datapath, driven cycle by cycle by an
//   external controller. It computes one quotient bit per shift step and
//   corrects the result signs at the output.
//
//   Control handshake: initialize, load_divident and sh_en are single-cycle
//   command strobes with no ready/acknowledge. A command takes effect at the
//   rising CLK edge where it is high. When several are high together,
//   initialize wins over load_divident, and load_divident wins over sh_en.
//   A load_divident with divident_gt_divisor low is ignored, and so is an
//   sh_en once count has reached WIDTH. done stays high, and the results
//   stay valid, until the next initialize or RST.
//
//   A typical controller drives load_divident when divident_gt_divisor is
//   high and sh_en otherwise, and stops when done is seen.
//
// Ports
//   CLK                 in   clock, rising edge
//   RST                 in   synchronous active-high reset
//   initialize          in   sample operands and start a new division
//   load_divident       in   subtract the aligned divisor from the remainder
//   sh_en               in   shift the divisor right and the quotient left
//   sign                in   1 = signed, 0 = unsigned (sampled on initialize)
//   dividend, divisor   in   operands (sampled on initialize)
//   divident_gt_divisor out  remainder >= aligned divisor (comb, qualified)
//   done                out  division complete (comb)
//   quotient, remainder out  sign-corrected results
//   div_by_zero         out  divisor was sampled as zero (registered)
module divider_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             initialize,
  input  logic             load_divident,
  input  logic             sh_en,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             divident_gt_divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0]   r_q;      // partial remainder magnitude
  logic [2*WIDTH-1:0] d_q;      // divisor aligned against the remainder
  logic [WIDTH-1:0]   q_q;      // quotient magnitude
  logic [CW-1:0]      count_q;  // shift steps taken
  logic               busy_q;
  logic               neg_q_q;
  logic               neg_r_q;
  logic               dbz_q;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             divisor_zero;
  logic             gt;

  // Two's-complement negation of the most negative value gives the value
  // back. Read as unsigned, that is the correct magnitude.
  assign dividend_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_mag  = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign divisor_zero = (divisor == '0);

  // With a zero divisor the aligned divisor is 0, so the raw compare is
  // always true. Forcing it low turns a divide-by-zero into shift-only steps.
  // That leaves quotient = 0 and remainder = dividend.
  assign gt = busy_q && !dbz_q && ({{WIDTH{1'b0}}, r_q} >= d_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (initialize) begin
      r_q     <= dividend_mag;
      d_q     <= {divisor_mag, {WIDTH{1'b0}}};
      q_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b1;
      neg_q_q <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && !divisor_zero;
      neg_r_q <= sign && dividend[WIDTH-1];
      dbz_q   <= divisor_zero;
    end else if (load_divident && gt) begin
      r_q    <= r_q - d_q[WIDTH-1:0];
      q_q[0] <= 1'b1;
    end else if (sh_en && (count_q < COUNT_MAX)) begin
      d_q     <= d_q >> 1;
      q_q     <= q_q << 1;
      count_q <= count_q + 1'b1;
    end
  end

  assign divident_gt_divisor = gt;
  assign done        = busy_q && (count_q == COUNT_MAX) && !gt;
  assign quotient    = neg_q_q ? -q_q : q_q;
  assign remainder   = neg_r_q ? -r_q : r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/divider_datapath.md
DIVIDER_DATAPATH -- requirements
Module: divider_datapath

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; all widths below assume WIDTH=32.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 initialize  in  1  load operands and start a new division.
REQ-005 load_divident  in  1  subtract the aligned divisor from the partial remainder this cycle.
REQ-006 sh_en  in  1  shift the aligned divisor right and the quotient left this cycle.
REQ-007 sign  in  1  1 = signed (div), 0 = unsigned (divu); sampled on initialize.
REQ-008 dividend  in  32  sampled on initialize.
REQ-009 divisor  in  32  sampled on initialize.
REQ-010 divident_gt_divisor  out  1  combinational: partial remainder >= aligned divisor, qualified (REQ-016).
REQ-011 done  out  1  combinational: division complete, results valid.
REQ-012 quotient  out  32  sign-corrected quotient.
REQ-013 remainder  out  32  sign-corrected remainder.
REQ-014 div_by_zero  out  1  registered: divisor sampled as zero.

Function
REQ-015 Internal state: 32-bit R (partial remainder magnitude), 64-bit D (aligned divisor), 32-bit Q, 6-bit count, busy, neg_q, neg_r, dbz.
REQ-016 divident_gt_divisor = busy & ~dbz & ({32'b0,R} >= D), unsigned 64-bit compare.
REQ-017 On initialize: R = |dividend|, D = |divisor| << 32, Q = 0, count = 0, busy = 1, dbz = (divisor == 0).
REQ-018 Magnitudes: when sign=0, operands are used as-is; when sign=1, negative operands are two's-complement negated (|0x80000000| = 0x80000000 unsigned).
REQ-019 On initialize: neg_q = sign & (dividend[31] ^ divisor[31]) & (divisor != 0); neg_r = sign & dividend[31].
REQ-020 On load_divident while divident_gt_divisor = 1: R = R - D[31:0], Q[0] = 1; D and count are held.
REQ-021 load_divident while divident_gt_divisor = 0 is ignored.
REQ-022 On sh_en while count < 32: D = D >> 1, Q = Q << 1, count = count + 1.
REQ-023 sh_en while count == 32 is ignored; count saturates at 32.
REQ-024 Priority when control inputs are asserted together: initialize > load_divident > sh_en.
REQ-025 done = busy & (count == 32) & ~divident_gt_divisor.
REQ-026 quotient = neg_q ? -Q : Q; remainder = neg_r ? -R : R (low 32 bits); -0 = 0.
REQ-027 Results and done hold after completion until the next initialize or RST.
REQ-028 Latency from the first OPER cycle to the done cycle inclusive: 33 + popcount(|quotient|) cycles.
REQ-029 Divide by zero: compare forced 0, 33 shift cycles, quotient = 0, remainder = dividend, div_by_zero = 1.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0, div_by_zero = 0; no overflow flag.
REQ-031 initialize mid-division aborts the current operation and restarts with the newly sampled operands.

Reset
REQ-032 RST = 1 at a clock edge clears R, D, Q, count, busy, neg_q, neg_r and dbz to 0, regardless of other inputs.
REQ-033 After reset: quotient = 0, remainder = 0, done = 0, div_by_zero = 0, divident_gt_divisor = 0.

Verification
REQ-034 Unsigned 100 / 7 driven through the controller -> quotient = 14, remainder = 2, done after 36 OPER cycles.
REQ-035 Signed -7 / 2 -> quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
REQ-036 Unsigned 0xFFFFFFFF / 1 -> quotient = 0xFFFFFFFF, remainder = 0, done after 65 cycles.
REQ-037 5 / 0 -> div_by_zero = 1, quotient = 0, remainder = 5, done after 33 cycles, no load_divident seen.
REQ-038 Signed 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0.
REQ-039 RST pulsed on the 10th OPER cycle of 100 / 7 -> next cycle: all outputs 0; a following 9 / 3 gives quotient = 3, remainder = 0.
